// File: rtl/wb_arb_pkg.sv
// Shared types and the round-robin pick function for the Wishbone arbiter.
package wb_arb_pkg;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} arb_state_t;

  localparam int MAX_NM = 8;

  // One-hot pick of the first requester scanning last+1, last+2, ... modulo nm.
  function automatic logic [MAX_NM-1:0] rr_next(input logic [MAX_NM-1:0] req,
                                                input logic [2:0] last,
                                                input int nm);
    logic [MAX_NM-1:0] g;
    logic              found;
    logic [2:0]        idx;
    g     = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= MAX_NM; k++) begin
      if (k <= nm && !found) begin
        idx = 3'((int'(last) + k) % nm);
        if (req[idx]) begin
          g[idx] = 1'b1;
          found  = 1'b1;
        end
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/wb_arb_wdog.sv
// Stall watchdog: counts stalled strobe cycles and flags a timeout at TO_CYC.
module wb_arb_wdog #(
  parameter int TO_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic busy,
  input  logic stb_act,
  input  logic resp,
  output logic tmo
);

  localparam int WW = (TO_CYC > 0) ? $clog2(TO_CYC + 1) : 1;
  localparam logic [WW-1:0] TO_V = WW'(TO_CYC);

  logic [WW-1:0] wdog;

  // TO_CYC of 0 keeps the counter pinned at zero and tmo low.
  assign tmo = (TO_CYC > 0) && (wdog == TO_V);

  always_ff @(posedge clk) begin
    if (rst || !busy || !stb_act || resp || tmo) begin
      wdog <= '0;
    end else if (wdog != TO_V) begin
      wdog <= wdog + 1'b1;
    end
  end

endmodule

// File: rtl/wb_rr_arb.sv
// Round-robin Wishbone arbiter: one master owns the slave per tenure, with a
// stall watchdog that ends dead slave cycles with an error.
module wb_rr_arb
  import wb_arb_pkg::*;
#(
  parameter int NM     = 4,
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int TO_CYC = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NM*AW-1:0]     m_adr,
  input  logic [NM*DW-1:0]     m_din,
  input  logic [NM*DW/8-1:0]   m_sel,
  input  logic [NM-1:0]        m_we,
  input  logic [NM-1:0]        m_cyc,
  input  logic [NM-1:0]        m_stb,
  output logic [DW-1:0]        m_dout,
  output logic [NM-1:0]        m_ack,
  output logic [NM-1:0]        m_err,
  output logic [NM-1:0]        m_rty,
  output logic [AW-1:0]        s_adr,
  output logic [DW-1:0]        s_dout,
  input  logic [DW-1:0]        s_din,
  output logic [DW/8-1:0]      s_sel,
  output logic                 s_we,
  output logic                 s_cyc,
  output logic                 s_stb,
  input  logic                 s_ack,
  input  logic                 s_err,
  input  logic                 s_rty,
  output logic [NM-1:0]        gnt
);

  localparam int SW = DW / 8;
  localparam int IW = (NM > 1) ? $clog2(NM) : 1;

  // Handshake: a beat is offered while cyc & stb are high and completes in the
  // cycle the slave raises exactly one of ack/err/rty; cyc low ends the tenure.
  arb_state_t        state, state_nxt;
  logic [NM-1:0]     gnt_nxt;
  logic [IW-1:0]     last, last_nxt, own;
  logic [MAX_NM-1:0] rr_req, rr_gnt;
  logic              busy, tmo;

  assign busy   = (state == BUSY);
  assign m_dout = s_din;

  always_comb begin
    own = '0;
    for (int i = 0; i < NM; i++) begin
      if (gnt[i]) own = IW'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= '0;
      last  <= IW'(NM - 1);
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      last  <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    last_nxt  = last;
    rr_req    = '0;
    rr_req[NM-1:0] = m_cyc;
    rr_gnt    = rr_next(rr_req, 3'(last), NM);
    case (state)
      IDLE: begin
        if (|m_cyc) begin
          gnt_nxt   = rr_gnt[NM-1:0];
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (!m_cyc[own]) begin
          state_nxt = IDLE;
          last_nxt  = own;
          gnt_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request mux toward the slave and response demux back to the owner only.
  always_comb begin
    s_cyc  = 1'b0;
    s_stb  = 1'b0;
    s_we   = 1'b0;
    s_adr  = '0;
    s_dout = '0;
    s_sel  = '0;
    m_ack  = '0;
    m_err  = '0;
    m_rty  = '0;
    if (busy) begin
      s_cyc      = m_cyc[own];
      s_stb      = m_stb[own] & ~tmo;
      s_we       = m_we[own];
      s_adr      = m_adr[int'(own)*AW +: AW];
      s_dout     = m_din[int'(own)*DW +: DW];
      s_sel      = m_sel[int'(own)*SW +: SW];
      m_ack[own] = s_ack;
      m_err[own] = s_err | tmo;
      m_rty[own] = s_rty;
    end
  end

  wb_arb_wdog #(.TO_CYC(TO_CYC)) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .busy    (busy),
    .stb_act (s_cyc & m_stb[own]),
    .resp    (s_ack | s_err | s_rty),
    .tmo     (tmo)
  );

endmodule

// File: tb/tb_wb_rr_arb.sv
// Bench for wb_rr_arb: four master drivers, a registered-ack memory slave,
// a grant-order monitor and a read-data scoreboard.
module tb_wb_rr_arb;

  localparam int NM = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO_CYC = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [AW-1:0] adr_a [NM];
  logic [DW-1:0] dat_a [NM];
  logic [SW-1:0] sel_a [NM];
  logic          we_a  [NM];
  logic          cyc_a [NM];
  logic          stb_a [NM];

  logic [NM*AW-1:0] m_adr;
  logic [NM*DW-1:0] m_din;
  logic [NM*SW-1:0] m_sel;
  logic [NM-1:0]    m_we, m_cyc, m_stb;
  logic [DW-1:0]    m_dout;
  logic [NM-1:0]    m_ack, m_err, m_rty, gnt;
  logic [AW-1:0]    s_adr;
  logic [DW-1:0]    s_dout, s_din;
  logic [SW-1:0]    s_sel;
  logic             s_we, s_cyc, s_stb, s_ack, s_err, s_rty;

  always_comb begin
    for (int i = 0; i < NM; i++) begin
      m_adr[i*AW +: AW] = adr_a[i];
      m_din[i*DW +: DW] = dat_a[i];
      m_sel[i*SW +: SW] = sel_a[i];
      m_we[i]  = we_a[i];
      m_cyc[i] = cyc_a[i];
      m_stb[i] = stb_a[i];
    end
  end

  wb_rr_arb #(.NM(NM), .AW(AW), .DW(DW), .TO_CYC(TO_CYC)) dut (
    .clk(clk), .rst(rst),
    .m_adr(m_adr), .m_din(m_din), .m_sel(m_sel), .m_we(m_we),
    .m_cyc(m_cyc), .m_stb(m_stb),
    .m_dout(m_dout), .m_ack(m_ack), .m_err(m_err), .m_rty(m_rty),
    .s_adr(s_adr), .s_dout(s_dout), .s_din(s_din), .s_sel(s_sel),
    .s_we(s_we), .s_cyc(s_cyc), .s_stb(s_stb),
    .s_ack(s_ack), .s_err(s_err), .s_rty(s_rty),
    .gnt(gnt)
  );

  // slave memory model, one registered ack per strobe
  logic [DW-1:0] mem [16];
  logic [DW-1:0] s_rdat;
  logic          slave_en;
  assign s_din = s_rdat;
  assign s_err = 1'b0;
  assign s_rty = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      s_ack <= 1'b0;
    end else begin
      s_ack <= 1'b0;
      if (slave_en && s_cyc && s_stb && !s_ack) begin
        s_ack  <= 1'b1;
        s_rdat <= mem[s_adr[5:2]];
        if (s_we) begin
          for (int b = 0; b < SW; b++) begin
            if (s_sel[b]) mem[s_adr[5:2]][b*8 +: 8] <= s_dout[b*8 +: 8];
          end
        end
      end
    end
  end

  // scoreboard state
  logic [DW-1:0] ref_mem [16];
  logic [DW-1:0] exp_q[$];
  logic [NM-1:0] exp_gnt_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // grant-order monitor
  logic          mon_en = 1'b0;
  logic          gap_en = 1'b0;
  logic          have_prev = 1'b0;
  int            idle_cnt = 0;
  logic [NM-1:0] prev_gnt = '0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (gnt != '0 && prev_gnt == '0) begin
        if (exp_gnt_q.size() == 0) check("gnt_extra", 64'(gnt), 64'd0);
        else check("gnt_order", 64'(gnt), 64'(exp_gnt_q.pop_front()));
        if (gap_en && have_prev) check("idle_gap", 64'(idle_cnt), 64'd1);
        have_prev = 1'b1;
        idle_cnt  = 0;
      end else if (gnt == '0) begin
        idle_cnt++;
      end
    end
    prev_gnt = gnt;
  end

  // driver tasks (all called in the phase just after a rising edge)
  task automatic set_m(input int i, input logic cyc, input logic stb, input logic we,
                       input logic [AW-1:0] adr, input logic [DW-1:0] dat);
    cyc_a[i] = cyc;
    stb_a[i] = stb;
    we_a[i]  = we;
    adr_a[i] = adr;
    dat_a[i] = dat;
    sel_a[i] = 4'hF;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < NM; i++) set_m(i, 1'b0, 1'b0, 1'b0, '0, '0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    have_prev = 1'b0;
    idle_cnt  = 0;
    gap_en    = 1'b0;
  endtask

  task automatic beat(input int i, input logic we, input logic [AW-1:0] adr,
                      input logic [DW-1:0] dat, input logic last);
    logic got;
    int   n;
    set_m(i, 1'b1, 1'b1, we, adr, dat);
    if (we) ref_mem[adr[5:2]] = dat;
    else exp_q.push_back(ref_mem[adr[5:2]]);
    got = 1'b0;
    n   = 0;
    while (!got && n < 200) begin
      @(negedge clk);
      if (m_ack[i] || m_err[i]) got = 1'b1;
      else n++;
    end
    check("beat_done", 64'(got), 64'd1);
    if (got) begin
      check("ack_onehot", 64'(m_ack), 64'(4'b0001 << i));
      check("gnt_hold", 64'(gnt), 64'(4'b0001 << i));
      if (!we) check("rd_data", 64'(m_dout), 64'(exp_q.pop_front()));
    end
    @(posedge clk);
    #1;
    stb_a[i] = 1'b0;
    if (last) cyc_a[i] = 1'b0;
  endtask

  task automatic tenure(input int i, input logic [AW-1:0] adr);
    beat(i, 1'b1, adr, $urandom(), 1'b0);
    beat(i, 1'b0, adr, '0, 1'b1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int stall, extra;
    logic got_err;
    for (int k = 0; k < 16; k++) begin
      mem[k]     = '0;
      ref_mem[k] = '0;
    end
    slave_en = 1'b1;
    rst = 1'b1;
    for (int i = 0; i < NM; i++) set_m(i, 1'b0, 1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", 64'(gnt), 64'd0);
    check("rst_s_cyc", 64'(s_cyc), 64'd0);
    check("rst_s_stb", 64'(s_stb), 64'd0);
    check("rst_s_we", 64'(s_we), 64'd0);
    check("rst_s_adr", 64'(s_adr), 64'd0);
    check("rst_s_sel", 64'(s_sel), 64'd0);
    check("rst_resp", 64'({m_ack, m_err, m_rty}), 64'd0);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;

    // single master write then read back
    exp_gnt_q.push_back(4'b0001);
    set_m(0, 1'b1, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
    @(negedge clk);
    check("gnt_lat0", 64'(gnt), 64'd0);
    @(negedge clk);
    check("gnt_lat1", 64'(gnt), 64'b0001);
    check("s_adr_mux", 64'(s_adr), 64'h10);
    check("s_dout_mux", 64'(s_dout), 64'hDEADBEEF);
    check("s_sel_mux", 64'(s_sel), 64'hF);
    check("s_we_mux", 64'(s_we), 64'd1);
    beat(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    beat(0, 1'b0, 32'h10, '0, 1'b1);
    repeat (2) @(posedge clk);
    #1;

    // ack coincident with cyc drop
    exp_gnt_q.push_back(4'b0001);
    set_m(0, 1'b1, 1'b1, 1'b1, 32'h14, 32'h12345678);
    ref_mem[5] = 32'h12345678;
    @(negedge clk);
    @(negedge clk);
    check("coin_gnt", 64'(gnt), 64'b0001);
    @(posedge clk);
    #1;
    set_m(0, 1'b0, 1'b0, 1'b1, 32'h14, 32'h12345678);
    @(negedge clk);
    check("coin_ack", 64'(m_ack), 64'b0001);
    check("coin_s_cyc", 64'(s_cyc), 64'd0);
    @(negedge clk);
    check("coin_idle", 64'(gnt), 64'd0);
    @(posedge clk);
    #1;

    // fairness: all four masters, two 2-beat tenures each
    do_reset();
    gap_en = 1'b1;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NM; i++) exp_gnt_q.push_back(NM'(1 << i));
    fork
      begin tenure(0, 32'h40); tenure(0, 32'h40); end
      begin tenure(1, 32'h44); tenure(1, 32'h44); end
      begin tenure(2, 32'h48); tenure(2, 32'h48); end
      begin tenure(3, 32'h4C); tenure(3, 32'h4C); end
    join
    repeat (2) @(posedge clk);
    #1;

    // burst hold: m2 keeps the bus for 8 beats while m0 waits
    do_reset();
    gap_en = 1'b1;
    exp_gnt_q.push_back(4'b0100);
    exp_gnt_q.push_back(4'b0001);
    fork
      begin
        for (int b = 0; b < 8; b++) beat(2, 1'b1, 32'h20 + 32'(b * 4), $urandom(), (b == 7));
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        beat(0, 1'b0, 32'h20, '0, 1'b1);
      end
    join
    repeat (2) @(posedge clk);
    #1;

    // watchdog timeout against a dead slave
    do_reset();
    slave_en = 1'b0;
    exp_gnt_q.push_back(4'b0010);
    set_m(1, 1'b1, 1'b1, 1'b0, 32'h30, '0);
    stall   = 0;
    got_err = 1'b0;
    for (int n = 0; n < 30 && !got_err; n++) begin
      @(negedge clk);
      if (m_err[1]) got_err = 1'b1;
      else if (gnt != '0) stall++;
    end
    check("tmo_seen", 64'(got_err), 64'd1);
    check("tmo_stall_cycles", 64'(stall), 64'd4);
    check("tmo_s_stb", 64'(s_stb), 64'd0);
    check("tmo_err_vec", 64'(m_err), 64'b0010);
    @(posedge clk);
    #1;
    set_m(1, 1'b0, 1'b0, 1'b0, '0, '0);
    extra = 0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (m_err != '0) extra++;
    end
    check("tmo_single_pulse", 64'(extra), 64'd0);
    check("tmo_idle", 64'(gnt), 64'd0);
    @(posedge clk);
    #1;

    // reset in the middle of m3's stalled read
    do_reset();
    exp_gnt_q.push_back(4'b1000);
    set_m(3, 1'b1, 1'b1, 1'b0, 32'h3C, '0);
    @(negedge clk);
    @(negedge clk);
    check("rmid_gnt3", 64'(gnt), 64'b1000);
    @(posedge clk);
    #1;
    rst = 1'b1;
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h10, '0);
    @(negedge clk);
    @(negedge clk);
    check("rmid_gnt", 64'(gnt), 64'd0);
    check("rmid_s_cyc", 64'(s_cyc), 64'd0);
    check("rmid_resp", 64'({m_ack, m_err, m_rty}), 64'd0);
    @(posedge clk);
    #1;
    exp_gnt_q.push_back(4'b0001);
    rst = 1'b0;
    cyc_a[3] = 1'b0;
    stb_a[3] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rmid_m0_first", 64'(gnt), 64'b0001);
    @(posedge clk);
    #1;
    set_m(0, 1'b0, 1'b0, 1'b0, '0, '0);
    slave_en = 1'b1;
    repeat (3) @(posedge clk);

    check("gnt_q_left", 64'(exp_gnt_q.size()), 64'd0);
    check("rd_q_left", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_rr_arb.md
Name: wb_rr_arb

Overview:
- Round-robin Wishbone arbiter that lets NM bus masters share one Wishbone slave, such as the bench memory model or a DMA-side memory port.
- Sits between the masters and the slave: grants one master per bus tenure and muxes that master's request signals onto the slave.
- Routes slave responses back to the granted master only.
- Includes a watchdog that terminates stalled slave cycles with an error, so a dead slave cannot lock the bus.

Parameters:
- NM, 4, number of masters (2..8).
- AW, 32, address width.
- DW, 32, data width. Select width is DW/8.
- TO_CYC, 255, stall-timeout length in cycles. 0 disables the watchdog.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- m_adr  in  NM*AW  master addresses, master i at bits [i*AW +: AW].
- m_din  in  NM*DW  master write data.
- m_sel  in  NM*DW/8  master byte selects.
- m_we  in  NM  master write enables.
- m_cyc  in  NM  master cycle requests.
- m_stb  in  NM  master strobes.
- m_dout  out  DW  slave read data, broadcast to all masters.
- m_ack  out  NM  per-master acknowledge.
- m_err  out  NM  per-master error.
- m_rty  out  NM  per-master retry.
- s_adr  out  AW  slave address.
- s_dout  out  DW  slave write data.
- s_din  in  DW  slave read data.
- s_sel  out  DW/8  slave byte selects.
- s_we  out  1  slave write enable.
- s_cyc  out  1  slave cycle.
- s_stb  out  1  slave strobe.
- s_ack  in  1  slave acknowledge.
- s_err  in  1  slave error.
- s_rty  in  1  slave retry.
- gnt  out  NM  one-hot registered grant, for status and debug.

Behaviour:
- Reset state, taken at the first rising edge with rst=1:
  - state=IDLE, gnt=0, last=NM-1 (so master 0 has first priority), wdog=0.
  - s_cyc, s_stb, s_we all 0; s_adr, s_dout, s_sel 0.
  - m_ack, m_err, m_rty all 0.
- Reset mid-tenure aborts the tenure. s_cyc falls at that edge, and no response is forwarded afterwards.
- States: IDLE and BUSY.
- IDLE:
  - If any m_cyc is high, select the first requesting index scanning last+1, last+2, ... modulo NM.
  - Register that index as gnt (one-hot) and go to BUSY.
  - Arbitration latency is 1 cycle: s_cyc first rises the cycle after the request is seen.
  - If no m_cyc is high, stay in IDLE.
- BUSY, combinational paths from the owner o:
  - s_cyc = m_cyc[o]; s_stb = m_stb[o] & ~tmo; s_adr, s_dout, s_sel, s_we come from master o.
  - m_ack[o] = s_ack, m_err[o] = s_err | tmo, m_rty[o] = s_rty; all other masters' response bits are 0.
  - m_dout = s_din at all times.
- BUSY exit:
  - When m_cyc[o]=0, s_cyc is 0 in that same cycle (combinational).
  - At the next edge: state=IDLE, last=o, gnt=0.
  - There is always at least one idle cycle between tenures.
- Ownership is held across any number of stb beats while the owner's cyc stays high. There is no preemption.
- A slave response arriving in the same cycle the owner drops cyc is still forwarded to the owner.
- Any response seen while in IDLE is discarded.
- Watchdog (active when TO_CYC>0):
  - wdog increments each cycle that s_cyc & m_stb[o] & ~(s_ack|s_err|s_rty).
  - It clears on any slave response, on stb low, and on leaving BUSY.
  - tmo = (wdog == TO_CYC). While tmo is high, the owner sees a 1-cycle m_err, s_stb is forced low, and wdog clears at that edge.
  - wdog width is clog2(TO_CYC+1) and it never wraps.
- Masters whose cyc is high but which are not granted see no response and simply wait.

Decomposition:
- Shared package wb_arb_pkg holds the state encoding (IDLE, BUSY) and the rr_next(req, last) function that returns the one-hot next grant.
- One sub-module, wb_arb_wdog, contains the watchdog counter and the tmo compare.
- The mux and FSM stay in wb_rr_arb.

Test Plan:
- Single master: m0 writes 0xDEADBEEF to adr 0x10 with sel=4'hF, then reads it back.
  - gnt=4'b0001 one cycle after m_cyc[0].
  - Read returns 0xDEADBEEF with m_ack[0] only; m_ack[3:1]=0.
- Fairness: m0..m3 request continuously, each doing 2-beat tenures.
  - Grant order is 0,1,2,3,0.
  - Exactly 1 idle cycle between tenures.
  - No master is granted twice before all the others are served.
- Burst hold: m2 holds cyc for 8 stb beats while m0 requests.
  - gnt stays 4'b0100 for all 8 acks.
  - m0 is granted the cycle after m2's cyc drops plus one.
- Timeout with TO_CYC=4 and a slave that never acks:
  - m1 sees exactly one m_err[1] pulse after 4 stalled cycles.
  - s_stb is low in the tmo cycle; then m1 drops cyc and the arbiter returns to IDLE.
- Reset mid-tenure: assert rst during m3's stalled read.
  - Next edge: gnt=0, s_cyc=0, all m_ack/m_err/m_rty=0.
  - After release, m0 wins first.
- Ack coincident with cyc drop on the last beat of m0's tenure: m_ack[0]=1 is forwarded and the FSM returns to IDLE at that edge.
